// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter and sequencer for a 4:1 data mux: grants one requester,
// drives the select and registers the selected data. Optional hold limit: MUX_ARB_HOLD_LIMIT_EN.
module mux4_rr_arbiter #(
    parameter int DATA_W   = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        req,
    input  logic [DATA_W-1:0] w0,
    input  logic [DATA_W-1:0] w1,
    input  logic [DATA_W-1:0] w2,
    input  logic [DATA_W-1:0] w3,
    output logic [3:0]        gnt,
    output logic [1:0]        s,
    output logic [DATA_W-1:0] f,
    output logic              valid
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
        $error("MAX_HOLD must be in 2..255");
    end

    state_t            state_q, state_d;
    logic [3:0]        gnt_q, gnt_d;
    logic [1:0]        s_q, s_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [DATA_W-1:0] f_q, f_d;
    logic              valid_q, valid_d;
    logic              new_grant;
    logic [1:0]        new_owner;

`ifdef MUX_ARB_HOLD_LIMIT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0] hold_q, hold_d;
    logic [3:0] others;
`endif

    // First set bit of r scanning start, start+1, start+2, start+3 (mod 4); r must be non-zero.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [1:0] idx;
        rr_pick = start;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        gnt_d     = gnt_q;
        s_d       = s_q;
        ptr_d     = ptr_q;
        new_grant = 1'b0;
        new_owner = s_q;
`ifdef MUX_ARB_HOLD_LIMIT_EN
        hold_d    = hold_q;
        others    = req & ~gnt_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (req != 4'b0000) begin
                    new_grant = 1'b1;
                    new_owner = rr_pick(req, ptr_q + 2'd1);
                end
            end
            GRANT: begin
                if (req[s_q]) begin
`ifdef MUX_ARB_HOLD_LIMIT_EN
                    if (hold_q == HOLD_LAST && others != 4'b0000) begin
                        new_grant = 1'b1;
                        new_owner = rr_pick(others, s_q + 2'd1);
                    end else if (hold_q != HOLD_LAST) begin
                        hold_d = hold_q + 8'd1;
                    end
`endif
                end else if (req != 4'b0000) begin
                    new_grant = 1'b1;
                    new_owner = rr_pick(req, ptr_q + 2'd1);
                end else begin
                    state_d = IDLE;
                    gnt_d   = 4'b0000;
                end
            end
            default: state_d = IDLE;
        endcase

        if (new_grant) begin
            state_d = GRANT;
            gnt_d   = 4'b0001 << new_owner;
            s_d     = new_owner;
            ptr_d   = new_owner;
`ifdef MUX_ARB_HOLD_LIMIT_EN
            hold_d  = 8'd0;
`endif
        end

        valid_d = (state_d == GRANT);
        f_d     = '0;
        if (valid_d) begin
            unique case (s_d)
                2'd0: f_d = w0;
                2'd1: f_d = w1;
                2'd2: f_d = w2;
                2'd3: f_d = w3;
                default: f_d = '0;
            endcase
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            s_q     <= 2'b00;
            ptr_q   <= 2'b11;
            f_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            s_q     <= s_d;
            ptr_q   <= ptr_d;
            f_q     <= f_d;
            valid_q <= valid_d;
        end
    end

`ifdef MUX_ARB_HOLD_LIMIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hold_q <= 8'd0;
        else        hold_q <= hold_d;
    end
`endif

    assign gnt   = gnt_q;
    assign s     = s_q;
    assign f     = f_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: vector table plus hand-written reset,
// rotation and async-reset sequences (hold-limit sequence when MUX_ARB_HOLD_LIMIT_EN is defined).
module tb_mux4_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       w0, w1, w2, w3;
    logic [3:0] gnt;
    logic [1:0] s;
    logic       f;
    logic       valid;

    int n_checks = 0;
    int n_pass   = 0;

    mux4_rr_arbiter #(.DATA_W(1), .MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .w0    (w0),
        .w1    (w1),
        .w2    (w2),
        .w3    (w3),
        .gnt   (gnt),
        .s     (s),
        .f     (f),
        .valid (valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       w0, w1, w2, w3;
        logic [3:0] gnt;
        logic [1:0] s;
        logic       f;
        logic       valid;
    } vec_t;

    vec_t vec [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic check_out(input string tag, input logic [3:0] eg, input logic [1:0] es,
                             input logic ef, input logic ev);
        check({tag, ".gnt"},   32'(gnt),   32'(eg));
        check({tag, ".s"},     32'(s),     32'(es));
        check({tag, ".f"},     32'(f),     32'(ef));
        check({tag, ".valid"}, 32'(valid), 32'(ev));
    endtask

    // Assumes the caller sits on a falling edge; advances one rising edge and returns on the next falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [3:0] r);
        req   = r;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        //            req      w0 w1 w2 w3  gnt      s  f  v
        vec[0]  = '{4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0, 0};
        vec[1]  = '{4'b0100, 0, 0, 1, 0, 4'b0100, 2, 1, 1};
        vec[2]  = '{4'b0100, 1, 1, 0, 1, 4'b0100, 2, 0, 1};
        vec[3]  = '{4'b0000, 1, 1, 1, 1, 4'b0000, 2, 0, 0};
        vec[4]  = '{4'b0001, 1, 0, 0, 0, 4'b0001, 0, 1, 1};
        vec[5]  = '{4'b0011, 0, 1, 0, 0, 4'b0001, 0, 0, 1};
        vec[6]  = '{4'b0010, 0, 1, 0, 0, 4'b0010, 1, 1, 1};
        vec[7]  = '{4'b1011, 1, 0, 1, 1, 4'b0010, 1, 0, 1};
        vec[8]  = '{4'b1001, 1, 1, 1, 0, 4'b1000, 3, 0, 1};
        vec[9]  = '{4'b0001, 1, 0, 0, 1, 4'b0001, 0, 1, 1};
        vec[10] = '{4'b0001, 0, 1, 1, 1, 4'b0001, 0, 0, 1};
        vec[11] = '{4'b0000, 1, 1, 1, 1, 4'b0000, 0, 0, 0};
        vec[12] = '{4'b0001, 1, 0, 0, 0, 4'b0001, 0, 1, 1};
        vec[13] = '{4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0, 0};

        w0 = 1'b1; w1 = 1'b1; w2 = 1'b1; w3 = 1'b1;
        rst_n = 1'b0;
        req   = 4'b1111;

        // T1: reset holds outputs clear despite all requests high
        repeat (2) @(negedge clk);
        check_out("t1_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        check_out("t1_first", 4'b0001, 2'd0, 1'b1, 1'b1);

        // T3: rotation 0,1,2,3,0 with one-cycle release and no idle gap
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < 3; c++) begin
                check($sformatf("t3_o%0d_c%0d.s", k, c), 32'(s), 32'(k % 4));
                check($sformatf("t3_o%0d_c%0d.gnt", k, c), 32'(gnt), 32'(4'b0001 << (k % 4)));
                check($sformatf("t3_o%0d_c%0d.valid", k, c), 32'(valid), 32'd1);
                if (c < 2) step();
            end
            req = 4'b1111 & ~(4'b0001 << (k % 4));
            step();
            req = 4'b1111;
        end

        // Table: single grants, data tracking, re-arbitration, idle, sole-requester regrant
        w0 = 1'b0; w1 = 1'b0; w2 = 1'b0; w3 = 1'b0;
        do_reset(4'b0000);
        for (int i = 0; i < 14; i++) begin
            req = vec[i].req;
            w0  = vec[i].w0; w1 = vec[i].w1; w2 = vec[i].w2; w3 = vec[i].w3;
            step();
            check_out($sformatf("vec%0d", i), vec[i].gnt, vec[i].s, vec[i].f, vec[i].valid);
        end

        // T4: owner 1 data toggles follow one edge later; other inputs never reach f
        req = 4'b0010;
        step();
        for (int c = 0; c < 6; c++) begin
            w1 = c[0];
            w0 = ~c[0]; w2 = ~c[0]; w3 = ~c[0];
            step();
            check($sformatf("t4_c%0d.f", c), 32'(f), 32'(c[0]));
            check($sformatf("t4_c%0d.s", c), 32'(s), 32'd1);
        end
        req = 4'b0000;
        step();

        // T5: async reset mid-grant clears before the next edge; restart from requester 0
        w3  = 1'b1;
        req = 4'b1000;
        step();
        check_out("t5_pre", 4'b1000, 2'd3, 1'b1, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_out("t5_async", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        req = 4'b1001;
        w0  = 1'b0;
        rst_n = 1'b1;
        step();
        check_out("t5_restart", 4'b0001, 2'd0, 1'b0, 1'b1);

`ifdef MUX_ARB_HOLD_LIMIT_EN
        // T6: hold limit alternates 0 and 1 every four cycles; a sole requester holds indefinitely
        do_reset(4'b0011);
        step();
        for (int c = 0; c < 16; c++) begin
            check($sformatf("t6_alt%0d.s", c), 32'(s), 32'((c / 4) % 2));
            if (c < 15) step();
        end
        req = 4'b0001;
        for (int c = 0; c < 10; c++) begin
            step();
            check($sformatf("t6_solo%0d.gnt", c), 32'(gnt), 32'h1);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
